// File: rtl/multdiv.sv
// multdiv: 33-cycle signed multiply (radix-2 Booth) / divide (restoring) unit
// with restart-on-start, overflow/divide-by-zero exception and one-cycle ready pulse.
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [64:0] r_acc;
  logic [31:0] r_a, r_b, r_result;
  logic        r_exc, r_rdy, r_busy;
  logic        w_start, w_neg, w_bz, w_ge, w_mul_exc, w_div_exc;
  logic [32:0] w_sa, w_ma, w_sb, w_mb, w_m33, w_up, w_sum, w_rsh;
  logic [32:0] w_hi;
  logic [31:0] w_q, w_div_res;
  logic [64:0] w_mul_nx, w_div_nx;
  assign w_start = ctrl_MULT ^ ctrl_DIV;
  assign w_sa    = {data_operandA[31], data_operandA};
  assign w_ma    = data_operandA[31] ? -w_sa : w_sa;
  assign w_sb    = {r_b[31], r_b};
  assign w_mb    = r_b[31] ? -w_sb : w_sb;
  // Booth: the add is done one bit wider so the shifted-in sign survives -2^31 multiplicands
  assign w_m33    = {r_a[31], r_a};
  assign w_up     = {r_acc[64], r_acc[64:33]};
  assign w_sum    = (r_acc[1:0] == 2'b01) ? w_up + w_m33 :
                    (r_acc[1:0] == 2'b10) ? w_up - w_m33 : w_up;
  assign w_mul_nx = {w_sum, r_acc[32:1]};
  assign w_hi     = r_acc[64:32];
  assign w_mul_exc = ~((&w_hi) | ~(|w_hi));
  // Restoring divide: remainder in r_acc[64:32], quotient shifts into r_acc[31:0]
  assign w_rsh     = r_acc[63:31];
  assign w_ge      = w_rsh >= w_mb;
  assign w_div_nx  = {w_ge ? w_rsh - w_mb : w_rsh, r_acc[30:0], w_ge};
  assign w_q       = r_acc[31:0];
  assign w_neg     = r_a[31] ^ r_b[31];
  assign w_bz      = r_b == 32'd0;
  assign w_div_res = w_bz ? 32'd0 : w_neg ? -w_q : w_q;
  assign w_div_exc = w_bz | (~w_neg & w_q[31]);
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
    end else if (w_start) begin
      r_state <= ctrl_MULT ? MUL : DIV;
      r_cnt   <= '0;
      r_a     <= data_operandA;
      r_b     <= data_operandB;
      r_acc   <= ctrl_MULT ? {32'd0, data_operandB, 1'b0} : {32'd0, w_ma};
      r_exc   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b1;
    end else if (r_state == MUL || r_state == DIV) begin
      if (r_cnt == 6'd32) begin
        r_state  <= DONE;
        r_result <= (r_state == MUL) ? r_acc[32:1] : w_div_res;
        r_exc    <= (r_state == MUL) ? w_mul_exc : w_div_exc;
        r_rdy    <= 1'b1;
        r_busy   <= 1'b0;
      end else begin
        r_acc <= (r_state == MUL) ? w_mul_nx : w_div_nx;
        r_cnt <= r_cnt + 6'd1;
      end
    end else if (r_state == DONE) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
    end
  end
  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for multdiv covering latency, results,
// exceptions, restart, mid-operation reset and conflicting start requests.
module tb_multdiv;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic        ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;
  int          n_checks = 0, n_fail = 0;
  // {A, B, expected result, expected exception}
  logic [96:0] mul_v [7] = '{
    {32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0},
    {32'h00010000, 32'h00010000, 32'h00000000, 1'b1},
    {32'h80000000, 32'h00000001, 32'h80000000, 1'b0},
    {32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
    {32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b1},
    {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0},
    {32'h00000000, 32'h12345678, 32'h00000000, 1'b0}};
  logic [96:0] div_v [7] = '{
    {32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},
    {32'h00000005, 32'h00000000, 32'h00000000, 1'b1},
    {32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
    {32'h00000064, 32'h00000007, 32'h0000000E, 1'b0},
    {32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},
    {32'h80000000, 32'h00000002, 32'hC0000000, 1'b0},
    {32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0}};

  multdiv dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy));

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start an op on the next edge, scramble operands, then count edges until ready (bounded).
  task automatic do_op(input logic m, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic busy_ok, output logic start_clr);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = !m;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = ~a;
    data_operandB = b ^ 32'h5A5A5A5A;
    start_clr = !data_exception && !data_resultRDY;
    lat = 0;
    busy_ok = 1'b1;
    while (!data_resultRDY && lat < 40) begin
      busy_ok &= busy;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    tick();
    tick();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    n_checks += 4;
    if (data_result !== 32'd0) begin n_fail++; $display("FAIL reset_result got %h want 0", data_result); end
    if (data_exception !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b want 0", data_exception); end
    if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", data_resultRDY); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_table(input logic m);
    int lat;
    logic bo, sc, e;
    logic [31:0] a, b, r;
    for (int i = 0; i < 7; i++) begin
      {a, b, r, e} = m ? mul_v[i] : div_v[i];
      do_op(m, a, b, lat, bo, sc);
      n_checks += 6;
      if (lat !== 33) begin n_fail++; $display("FAIL %s%0d latency got %0d want 33", m ? "mul" : "div", i, lat); end
      if (bo !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL %s%0d busy window got ok=%b end=%b want 1/0", m ? "mul" : "div", i, bo, busy); end
      if (sc !== 1'b1) begin n_fail++; $display("FAIL %s%0d start_clear got %b want 1", m ? "mul" : "div", i, sc); end
      if (data_result !== r) begin n_fail++; $display("FAIL %s%0d result got %h want %h", m ? "mul" : "div", i, data_result, r); end
      if (data_exception !== e) begin n_fail++; $display("FAIL %s%0d exc got %b want %b", m ? "mul" : "div", i, data_exception, e); end
      tick();
      if (data_resultRDY !== 1'b0 || data_result !== r) begin n_fail++; $display("FAIL %s%0d hold rdy=%b res=%h want 0/%h", m ? "mul" : "div", i, data_resultRDY, data_result, r); end
    end
  endtask

  task automatic test_restart();
    int lat;
    logic bo, sc, seen;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      tick();
      seen |= data_resultRDY;
    end
    do_op(1'b0, 32'd100, 32'd7, lat, bo, sc);
    n_checks += 4;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL restart_abandoned_rdy got %b want 0", seen); end
    if (lat !== 33) begin n_fail++; $display("FAIL restart_latency got %0d want 33", lat); end
    if (data_result !== 32'd14) begin n_fail++; $display("FAIL restart_result got %h want 0000000e", data_result); end
    tick();
    if (data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL restart_single_pulse got %b want 0", data_resultRDY); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic bo, sc;
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_DIV = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks += 4;
    if (data_result !== 32'd0) begin n_fail++; $display("FAIL midreset_result got %h want 0", data_result); end
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL midreset_flags busy=%b rdy=%b want 0/0", busy, data_resultRDY); end
    do_op(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, lat, bo, sc);
    if (lat !== 33) begin n_fail++; $display("FAIL midreset_mul_latency got %0d want 33", lat); end
    if (data_result !== 32'd6 || data_exception !== 1'b0) begin n_fail++; $display("FAIL midreset_mul got %h/%b want 00000006/0", data_result, data_exception); end
    tick();
  endtask

  task automatic test_both_high();
    logic seen_busy, seen_rdy;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    ctrl_DIV = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    seen_busy = busy;
    seen_rdy = data_resultRDY;
    repeat (40) begin
      tick();
      seen_busy |= busy;
      seen_rdy |= data_resultRDY;
    end
    n_checks += 3;
    if (seen_busy !== 1'b0) begin n_fail++; $display("FAIL both_busy got %b want 0", seen_busy); end
    if (seen_rdy !== 1'b0) begin n_fail++; $display("FAIL both_rdy got %b want 0", seen_rdy); end
    if (data_result !== 32'd6) begin n_fail++; $display("FAIL both_result got %h want 00000006", data_result); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic bo, sc;
    do_op(1'b1, 32'd7, 32'hFFFFFFFA, lat, bo, sc);
    do_op(1'b0, 32'hFFFFFFF9, 32'd2, lat, bo, sc);
    n_checks += 3;
    if (sc !== 1'b1) begin n_fail++; $display("FAIL b2b_start_clear got %b want 1", sc); end
    if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
    if (data_result !== 32'hFFFFFFFD || data_exception !== 1'b0) begin n_fail++; $display("FAIL b2b_result got %h/%b want fffffffd/0", data_result, data_exception); end
    tick();
  endtask

  initial begin
    test_reset();
    test_table(1'b1);
    test_table(1'b0);
    test_restart();
    test_reset_mid();
    test_both_high();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have no parameters; latency and widths are fixed.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL provide port `clock`: input, 1 bit, rising-edge clock for all state.
REQ-004 SHALL provide port `reset`: input, 1 bit, synchronous active-high clear.
REQ-005 SHALL provide port `data_operandA`: input, 32 bits, signed multiplicand or dividend.
REQ-006 SHALL provide port `data_operandB`: input, 32 bits, signed multiplier or divisor.
REQ-007 SHALL provide port `ctrl_MULT`: input, 1 bit, start-multiply pulse.
REQ-008 SHALL provide port `ctrl_DIV`: input, 1 bit, start-divide pulse.
REQ-009 SHALL provide port `data_result`: output, 32 bits, registered result; this feeds the ALU `multdivAns` input.
REQ-010 SHALL provide port `data_exception`: output, 1 bit, registered error flag qualified by `data_resultRDY`.
REQ-011 SHALL provide port `data_resultRDY`: output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL provide port `busy`: output, 1 bit, high while an operation is in progress.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV and DONE.
- IDLE -> MUL on `ctrl_MULT`.
- IDLE -> DIV on `ctrl_DIV`.
- MUL/DIV -> DONE after 32 iteration edges.
- DONE -> IDLE on the next edge, unless a start is present.
REQ-014 SHALL, on the edge that samples a start, latch both operands internally; operand inputs are don't-care afterwards.
REQ-015 SHALL ignore the request when `ctrl_MULT` and `ctrl_DIV` are both high on the same edge; state and outputs are unchanged.
REQ-016 SHALL, if a valid start is sampled in MUL, DIV or DONE, abandon the current operation and restart with the new operands; no `data_resultRDY` pulse is produced for the abandoned operation.
REQ-017 SHALL perform multiply as radix-2 Booth over 32 iterations on a 65-bit accumulator, one iteration per clock.
REQ-018 SHALL perform divide as restoring division on operand magnitudes, with 32 iterations of one quotient bit per clock.
REQ-019 SHALL drive `data_result`, `data_exception` and `data_resultRDY` from registers updated on the 33rd rising edge after the start edge; `data_resultRDY` SHALL be 1 for exactly that following cycle.
REQ-020 SHALL hold `data_result` and `data_exception` from completion until the next start edge or reset.
REQ-021 SHALL clear `data_resultRDY` and `data_exception` to 0 on the start edge.
REQ-022 SHALL hold `busy` at 1 from the cycle after the start edge through the cycle before `data_resultRDY` rises.
REQ-023 SHALL set the multiply result to product[31:0].
REQ-024 SHALL set the multiply exception to 1 when product[63:31] are not all equal, i.e. the product does not fit in signed 32 bits.
REQ-025 SHALL truncate the divide quotient toward zero, with quotient sign = A[31] XOR B[31]; the remainder is discarded.
REQ-026 SHALL, for divisor 0, give `data_result` = 0x00000000 and `data_exception` = 1 at the normal 33-cycle latency.
REQ-027 SHALL, for 0x80000000 / 0xFFFFFFFF, give `data_result` = 0x80000000 and `data_exception` = 1.
REQ-028 SHALL handle operand 0x80000000 (magnitude 2^31) correctly, using 33-bit internal magnitudes.
REQ-029 SHALL use a 6-bit iteration counter that is cleared on the start edge and never wraps during an operation.

Reset
REQ-030 SHALL, when `reset` is 1 at a rising edge, go to IDLE and clear the counter and all datapath registers.
REQ-031 SHALL, after reset, give `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0 and `busy` = 0.
REQ-032 SHALL have reset override any simultaneous `ctrl_MULT`/`ctrl_DIV`.
REQ-033 SHALL, if reset occurs mid-operation, produce no `data_resultRDY` pulse for that operation.
REQ-034 SHALL accept a start on the first edge after reset deasserts.

Verification
REQ-035 SHALL pass: MULT with A=7, B=-6 -> 33 edges later `data_result`=0xFFFFFFD6, exception 0, `data_resultRDY` high for 1 cycle.
REQ-036 SHALL pass: MULT with A=0x00010000, B=0x00010000 -> `data_result`=0x00000000, exception 1.
REQ-037 SHALL pass: DIV with A=-7, B=2 -> `data_result`=0xFFFFFFFD, exception 0; DIV with A=5, B=0 -> `data_result`=0, exception 1.
REQ-038 SHALL pass: DIV with A=0x80000000, B=0xFFFFFFFF -> `data_result`=0x80000000, exception 1; MULT with A=0x80000000, B=1 -> `data_result`=0x80000000, exception 0.
REQ-039 SHALL pass: MULT 3*4 restarted at cycle 10 by DIV 100/7 -> a single `data_resultRDY` pulse 33 edges after the DIV start, `data_result`=14.
REQ-040 SHALL pass: `reset` at cycle 20 of a DIV -> outputs 0 next cycle, no ready pulse; then MULT -2*-3 -> `data_result`=6.
REQ-041 SHALL pass: `ctrl_MULT` and `ctrl_DIV` both high in IDLE -> `busy` stays 0 and no ready pulse occurs.
